// File: rtl/wb_ctrl_pkg.sv
// Shared defines for the writeback controller: register-file bus widths,
// the zero register, the write-enable level and the LSU response FIFO entry.
package wb_ctrl_pkg;

    localparam int unsigned RegAddrBus  = 5;
    localparam int unsigned RegBus      = 32;
    localparam int unsigned NumRegs     = 2 ** RegAddrBus;
    localparam int unsigned WbFifoDepth = 2;

    localparam logic [RegAddrBus-1:0] ZeroReg     = '0;
    localparam logic                  WriteEnable = 1'b1;

    // One buffered load response: destination register and its data (37 bits).
    typedef struct packed {
        logic [RegAddrBus-1:0] rd;
        logic [RegBus-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_ctrl_if.sv
// Pipeline-facing bundle of the writeback controller: EX/LSU result handshakes,
// load-issue scoreboard port, ID source lookups and the regfile write port.
interface wb_ctrl_if;
    import wb_ctrl_pkg::*;

    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [RegAddrBus-1:0] alu_rd_addr_i;
    logic [RegBus-1:0]     alu_rd_data_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [RegAddrBus-1:0] lsu_rd_addr_i;
    logic [RegBus-1:0]     lsu_rd_data_i;

    logic                  issue_valid_i;
    logic [RegAddrBus-1:0] issue_rd_addr_i;

    logic [RegAddrBus-1:0] rs1_addr_i;
    logic [RegAddrBus-1:0] rs2_addr_i;
    logic                  rs1_busy_o;
    logic                  rs2_busy_o;
    logic                  rs1_fwd_o;
    logic                  rs2_fwd_o;
    logic [RegBus-1:0]     rs1_fwd_data_o;
    logic [RegBus-1:0]     rs2_fwd_data_o;

    logic                  wen;
    logic [RegAddrBus-1:0] wr_addr_o;
    logic [RegBus-1:0]     wr_data_o;

    // Pipeline side: produces results, issues loads, looks up sources.
    modport master (
        output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        output issue_valid_i, issue_rd_addr_i, rs1_addr_i, rs2_addr_i,
        input  alu_ready_o, lsu_ready_o,
        input  rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o,
        input  rs1_fwd_data_o, rs2_fwd_data_o,
        input  wen, wr_addr_o, wr_data_o
    );

    // Writeback controller side.
    modport slave (
        input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        input  issue_valid_i, issue_rd_addr_i, rs1_addr_i, rs2_addr_i,
        output alu_ready_o, lsu_ready_o,
        output rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o,
        output rs1_fwd_data_o, rs2_fwd_data_o,
        output wen, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Two-entry synchronous FIFO buffering LSU load responses ahead of the
// regfile write port; push is ignored when full, pop is ignored when empty.
module wb_fifo
    import wb_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = $clog2(WbFifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t       mem [WbFifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            push_eff;
    logic            pop_eff;

    assign full     = (count == CntW'(WbFifoDepth));
    assign empty    = (count == '0);
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;
    assign dout     = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU results and buffered load responses onto
// the single regfile write port, tracks outstanding loads and exposes bypass.
module wb_ctrl
    import wb_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    wb_ctrl_if.slave  bus
);

    wb_entry_t             fifo_din;
    wb_entry_t             fifo_dout;
    wb_entry_t             sel;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  sel_valid;
    logic [NumRegs-1:0]    busy_q;
    logic [NumRegs-1:0]    busy_set;
    logic [NumRegs-1:0]    busy_clr;
    logic                  wen_q;
    logic [RegAddrBus-1:0] wr_addr_q;
    logic [RegBus-1:0]     wr_data_q;

    // Both producers stall only while the load buffer is full, and during reset.
    assign bus.lsu_ready_o = ~fifo_full & ~rstn;
    assign bus.alu_ready_o = ~fifo_full & ~rstn;

    assign fifo_push     = bus.lsu_valid_i & bus.lsu_ready_o;
    assign fifo_din.rd   = bus.lsu_rd_addr_i;
    assign fifo_din.data = bus.lsu_rd_data_i;

    wb_fifo u_fifo (
        .clk   (clk),
        .rst   (rstn),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-port arbitration: a full buffer drains first, otherwise ALU wins.
    always_comb begin
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel       = '0;
        if (fifo_full) begin
            fifo_pop  = 1'b1;
            sel_valid = 1'b1;
            sel       = fifo_dout;
        end else if (bus.alu_valid_i) begin
            sel_valid = 1'b1;
            sel.rd    = bus.alu_rd_addr_i;
            sel.data  = bus.alu_rd_data_i;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sel_valid = 1'b1;
            sel       = fifo_dout;
        end
    end

    // Set is applied after clear so a re-issue on the popping edge stays busy.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (bus.issue_valid_i && (bus.issue_rd_addr_i != ZeroReg))
            busy_set = NumRegs'(1) << bus.issue_rd_addr_i;
        if (fifo_pop)
            busy_clr = NumRegs'(1) << fifo_dout.rd;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) busy_q <= '0;
        else      busy_q <= (busy_q & ~busy_clr) | busy_set;
    end

    // x0 results are consumed without a write; address/data hold when idle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wen_q     <= ~WriteEnable;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wen_q <= ~WriteEnable;
            if (sel_valid && (sel.rd != ZeroReg)) begin
                wen_q     <= WriteEnable;
                wr_addr_q <= sel.rd;
                wr_data_q <= sel.data;
            end
        end
    end

    assign bus.wen       = wen_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;

    assign bus.rs1_busy_o = (bus.rs1_addr_i != ZeroReg) & busy_q[bus.rs1_addr_i];
    assign bus.rs2_busy_o = (bus.rs2_addr_i != ZeroReg) & busy_q[bus.rs2_addr_i];

    assign bus.rs1_fwd_o = (wen_q == WriteEnable) & (wr_addr_q == bus.rs1_addr_i)
                         & (bus.rs1_addr_i != ZeroReg);
    assign bus.rs2_fwd_o = (wen_q == WriteEnable) & (wr_addr_q == bus.rs2_addr_i)
                         & (bus.rs2_addr_i != ZeroReg);

    assign bus.rs1_fwd_data_o = bus.rs1_fwd_o ? wr_data_q : '0;
    assign bus.rs2_fwd_data_o = bus.rs2_fwd_o ? wr_data_q : '0;

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic, every cycle checked
// against a queue-based model of the writeback rules.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    logic clk;
    logic rstn;
    wb_ctrl_if bus();

    wb_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy[32];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Compare every output against the model's view of the current cycle.
    task automatic check_all();
        logic        rdy;
        logic        f1, f2;
        logic [4:0]  a1, a2;
        a1  = bus.rs1_addr_i;
        a2  = bus.rs2_addr_i;
        rdy = (rstn === 1'b0) && (mq.size() < 2);
        f1  = m_wen && (m_addr == a1) && (a1 != 0);
        f2  = m_wen && (m_addr == a2) && (a2 != 0);
        check("alu_ready", 32'(bus.alu_ready_o), 32'(rdy));
        check("lsu_ready", 32'(bus.lsu_ready_o), 32'(rdy));
        check("wen",       32'(bus.wen), 32'(m_wen));
        check("wr_addr",   32'(bus.wr_addr_o), 32'(m_addr));
        check("wr_data",   bus.wr_data_o, m_data);
        check("rs1_busy",  32'(bus.rs1_busy_o), 32'((a1 != 0) && mbusy[a1]));
        check("rs2_busy",  32'(bus.rs2_busy_o), 32'((a2 != 0) && mbusy[a2]));
        check("rs1_fwd",   32'(bus.rs1_fwd_o), 32'(f1));
        check("rs2_fwd",   32'(bus.rs2_fwd_o), 32'(f2));
        check("rs1_fwd_data", bus.rs1_fwd_data_o, f1 ? m_data : 32'h0);
        check("rs2_fwd_data", bus.rs2_fwd_data_o, f2 ? m_data : 32'h0);
    endtask

    // Apply one clock edge of the writeback rules to the model state.
    task automatic model_edge();
        int   sz;
        bit   have;
        bit   popped;
        ent_t sel;
        if (rstn) return;
        sz     = mq.size();
        have   = 0;
        popped = 0;
        sel.rd = '0; sel.data = '0;
        if (sz == 2 || (!bus.alu_valid_i && sz > 0)) begin
            sel    = mq.pop_front();
            popped = 1;
            have   = 1;
        end else if (bus.alu_valid_i) begin
            sel.rd   = bus.alu_rd_addr_i;
            sel.data = bus.alu_rd_data_i;
            have     = 1;
        end
        if (popped) mbusy[sel.rd] = 1'b0;
        if (bus.issue_valid_i && bus.issue_rd_addr_i != 0) mbusy[bus.issue_rd_addr_i] = 1'b1;
        if (bus.lsu_valid_i && sz < 2) begin
            ent_t e;
            e.rd   = bus.lsu_rd_addr_i;
            e.data = bus.lsu_rd_data_i;
            mq.push_back(e);
        end
        m_wen = have && (sel.rd != 0);
        if (m_wen) begin
            m_addr = sel.rd;
            m_data = sel.data;
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid_i = 0; bus.alu_rd_addr_i = '0; bus.alu_rd_data_i = '0;
        bus.lsu_valid_i = 0; bus.lsu_rd_addr_i = '0; bus.lsu_rd_data_i = '0;
        bus.issue_valid_i = 0; bus.issue_rd_addr_i = '0;
        bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid_i = v; bus.alu_rd_addr_i = rd; bus.alu_rd_data_i = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lsu_valid_i = v; bus.lsu_rd_addr_i = rd; bus.lsu_rd_data_i = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] rd);
        bus.issue_valid_i = v; bus.issue_rd_addr_i = rd;
    endtask

    task automatic rs(input logic [4:0] a, input logic [4:0] b);
        bus.rs1_addr_i = a; bus.rs2_addr_i = b;
    endtask

    initial begin
        rstn = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rstn = 1'b0;
        tick();

        // ALU result written one cycle after acceptance and forwarded.
        alu(1, 5, 32'h1234); tick();
        idle(); rs(5, 0); #1;
        check("alu_wen", 32'(bus.wen), 32'h1);
        check("alu_fwd_data", bus.rs1_fwd_data_o, 32'h1234);
        tick();

        // Load path: busy until the pop edge, then write and forward together.
        idle(); iss(1, 7); tick();
        idle(); rs(0, 7); #1;
        check("load_busy_pre", 32'(bus.rs2_busy_o), 32'h1);
        lsu(1, 7, 32'hA5A5); tick();
        idle(); rs(0, 7); #1;
        check("load_wen_k1", 32'(bus.wen), 32'h0);
        tick();
        idle(); rs(0, 7); #1;
        check("load_wen_k2", 32'(bus.wen), 32'h1);
        check("load_busy_clr", 32'(bus.rs2_busy_o), 32'h0);
        check("load_fwd", 32'(bus.rs2_fwd_o), 32'h1);
        tick();

        // Full buffer: ALU wins until full, then stalls while a load drains.
        idle(); alu(1, 1, 32'hA1); lsu(1, 10, 32'hB1); tick();
        idle(); alu(1, 2, 32'hA2); lsu(1, 11, 32'hB2); tick();
        idle(); alu(1, 3, 32'hA3); lsu(1, 12, 32'hB3); #1;
        check("full_alu_ready", 32'(bus.alu_ready_o), 32'h0);
        tick();
        idle(); alu(1, 3, 32'hA3); tick();
        idle(); alu(1, 4, 32'hA4); tick();
        idle(); tick();
        tick();
        tick();

        // x0 destinations never write and never look busy.
        idle(); alu(1, 0, 32'hDEAD); lsu(1, 0, 32'hBEEF); iss(1, 0); tick();
        idle(); lsu(1, 0, 32'hCAFE); tick();
        repeat (3) begin idle(); tick(); end

        // Re-issue on the same edge the older load pops keeps the register busy.
        idle(); iss(1, 9); tick();
        idle(); lsu(1, 9, 32'h9999); tick();
        idle(); iss(1, 9); tick();
        idle(); rs(9, 0); #1;
        check("collide_busy", 32'(bus.rs1_busy_o), 32'h1);
        tick();

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            alu($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            lsu($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
            iss($urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
            rs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        // Asynchronous reset with a full buffer and three busy registers.
        repeat (3) begin idle(); tick(); end
        idle(); iss(1, 3); tick();
        idle(); iss(1, 4); tick();
        idle(); alu(1, 1, 32'h11); lsu(1, 20, 32'h20); iss(1, 6); tick();
        idle(); alu(1, 2, 32'h22); lsu(1, 21, 32'h21); tick();
        idle(); rs(3, 4);
        #2;
        rstn = 1'b1;
        model_reset();
        #1;
        check("arst_wen", 32'(bus.wen), 32'h0);
        check("arst_wr_data", bus.wr_data_o, 32'h0);
        check("arst_lsu_ready", 32'(bus.lsu_ready_o), 32'h0);
        check("arst_busy", 32'(bus.rs1_busy_o | bus.rs2_busy_o), 32'h0);
        tick();
        rstn = 1'b0;
        idle(); rs(3, 6); #1;
        check("post_rst_lsu_ready", 32'(bus.lsu_ready_o), 32'h1);
        tick();
        repeat (3) begin idle(); rs(4, 6); tick(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
